mini_src_datapath: RTL and testbench

- 32-bit bus-based datapath for the Mini-SRC CPU, phase 1. Contains sixteen general registers R0–R15, HI, LO, PC, IR, MAR, MDR, Y, a 64-bit Z, C, In_Port, a shared bus and an ALU.
- An external control-sequence testbench or controller drives every register load and bus-drive strobe one step at a time.

---
 rtl/mini_src_datapath.sv | 207 ++++++++++++++++++++
 tb/tb_mini_src_datapath.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mini_src_datapath.sv
`default_nettype none
// ============================================================================
// Module   : mini_src_datapath_reg / mini_src_datapath
// Purpose  : Mini-SRC phase-1 bus datapath. Sixteen general registers,
//            HI, LO, PC, IR, MAR, MDR, Y, 64-bit Z, C and In_Port share one
//            combinational bus feeding a combinational ALU (A = Y, B = bus).
// Ports    : clock, clear (sync active-low); *in strobes load registers,
//            *out strobes drive the bus (fixed priority, R0 highest);
//            Read selects MDR source; IncPC forces bus+1; Mdatain is memory
//            read data; ALU_Control selects the operation; Out_Portout
//            mirrors In_Port.
// Revision : 1.0 - initial release
// ============================================================================

// Generic load-enable register. The stored value is exposed as q so that
// instances can be observed hierarchically as <inst>.q.
module mini_src_datapath_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clock) begin
        if (!clear)      q <= '0;
        else if (i_load) q <= i_d;
    end
endmodule

module mini_src_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             R0in,  input logic R1in,  input logic R2in,  input logic R3in,
    input  logic             R4in,  input logic R5in,  input logic R6in,  input logic R7in,
    input  logic             R8in,  input logic R9in,  input logic R10in, input logic R11in,
    input  logic             R12in, input logic R13in, input logic R14in, input logic R15in,
    input  logic             HIin,
    input  logic             LOin,
    input  logic             Zhighin,
    input  logic             Zlowin,
    input  logic             PCin,
    input  logic             MDRin,
    input  logic             In_Portin,
    input  logic             Coutin,
    input  logic             Read,
    input  logic             IRin,
    input  logic             MARin,
    input  logic             Yin,
    input  logic             Zin,
    input  logic             R0out,  input logic R1out,  input logic R2out,  input logic R3out,
    input  logic             R4out,  input logic R5out,  input logic R6out,  input logic R7out,
    input  logic             R8out,  input logic R9out,  input logic R10out, input logic R11out,
    input  logic             R12out, input logic R13out, input logic R14out, input logic R15out,
    input  logic             HIout,
    input  logic             LOout,
    input  logic             Zhighout,
    input  logic             Zlowout,
    input  logic             PCout,
    input  logic             MDRout,
    input  logic             In_Portout,
    input  logic             Coutout,
    input  logic             IncPC,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic [4:0]       ALU_Control,
    output logic [WIDTH-1:0] Out_Portout
);
    localparam int       c_SHW      = $clog2(WIDTH);
    localparam logic [4:0] c_OP_ADD  = 5'b00000;
    localparam logic [4:0] c_OP_SUB  = 5'b00001;
    localparam logic [4:0] c_OP_AND  = 5'b00010;
    localparam logic [4:0] c_OP_OR   = 5'b00011;
    localparam logic [4:0] c_OP_NEG  = 5'b00100;
    localparam logic [4:0] c_OP_NOT  = 5'b00101;
    localparam logic [4:0] c_OP_SHR  = 5'b00110;
    localparam logic [4:0] c_OP_SHRA = 5'b00111;
    localparam logic [4:0] c_OP_SHL  = 5'b01000;
    localparam logic [4:0] c_OP_ROR  = 5'b01001;
    localparam logic [4:0] c_OP_ROL  = 5'b01010;
    localparam logic [4:0] c_OP_MUL  = 5'b01011;
    localparam logic [4:0] c_OP_DIV  = 5'b01100;

    logic [15:0]          w_rin;
    logic [15:0]          w_rout;
    logic [WIDTH-1:0]     w_r_q [16];
    logic [WIDTH-1:0]     w_bus;
    logic [WIDTH-1:0]     w_hi_q, w_lo_q, w_pc_q, w_ir_q, w_mar_q;
    logic [WIDTH-1:0]     w_mdr_q, w_mdr_d, w_y_q, w_c_q, w_inport_q;
    logic [2*WIDTH-1:0]   r_z;
    logic [2*WIDTH-1:0]   w_alu;
    logic                 w_unused_ok;

    assign w_rin  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                     R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
    assign w_rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                     R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

    // ---------------- register file and special registers ----------------
    mini_src_datapath_reg #(.WIDTH(WIDTH)) R0  (.clock(clock), .clear(clear), .i_load(w_rin[0]),  .i_d(w_bus), .q(w_r_q[0]));
    mini_src_datapath_reg #(.WIDTH(WIDTH)) R1  (.clock(clock), .clear(clear), .i_load(w_rin[1]),  .i_d(w_bus), .q(w_r_q[1]));
    mini_src_datapath_reg #(.WIDTH(WIDTH)) R2  (.clock(clock), .clear(clear), .i_load(w_rin[2]),  .i_d(w_bus), .q(w_r_q[2]));
    mini_src_datapath_reg #(.WIDTH(WIDTH)) R3  (.clock(clock), .clear(clear), .i_load(w_rin[3]),  .i_d(w_bus), .q(w_r_q[3]));
    mini_src_datapath_reg #(.WIDTH(WIDTH)) R4  (.clock(clock), .clear(clear), .i_load(w_rin[4]),  .i_d(w_bus), .q(w_r_q[4]));
    mini_src_datapath_reg #(.WIDTH(WIDTH)) R5  (.clock(clock), .clear(clear), .i_load(w_rin[5]),  .i_d(w_bus), .q(w_r_q[5]));
    mini_src_datapath_reg #(.WIDTH(WIDTH)) R6  (.clock(clock), .clear(clear), .i_load(w_rin[6]),  .i_d(w_bus), .q(w_r_q[6]));
    mini_src_datapath_reg #(.WIDTH(WIDTH)) R7  (.clock(clock), .clear(clear), .i_load(w_rin[7]),  .i_d(w_bus), .q(w_r_q[7]));
    mini_src_datapath_reg #(.WIDTH(WIDTH)) R8  (.clock(clock), .clear(clear), .i_load(w_rin[8]),  .i_d(w_bus), .q(w_r_q[8]));
    mini_src_datapath_reg #(.WIDTH(WIDTH)) R9  (.clock(clock), .clear(clear), .i_load(w_rin[9]),  .i_d(w_bus), .q(w_r_q[9]));
    mini_src_datapath_reg #(.WIDTH(WIDTH)) R10 (.clock(clock), .clear(clear), .i_load(w_rin[10]), .i_d(w_bus), .q(w_r_q[10]));
    mini_src_datapath_reg #(.WIDTH(WIDTH)) R11 (.clock(clock), .clear(clear), .i_load(w_rin[11]), .i_d(w_bus), .q(w_r_q[11]));
    mini_src_datapath_reg #(.WIDTH(WIDTH)) R12 (.clock(clock), .clear(clear), .i_load(w_rin[12]), .i_d(w_bus), .q(w_r_q[12]));
    mini_src_datapath_reg #(.WIDTH(WIDTH)) R13 (.clock(clock), .clear(clear), .i_load(w_rin[13]), .i_d(w_bus), .q(w_r_q[13]));
    mini_src_datapath_reg #(.WIDTH(WIDTH)) R14 (.clock(clock), .clear(clear), .i_load(w_rin[14]), .i_d(w_bus), .q(w_r_q[14]));
    mini_src_datapath_reg #(.WIDTH(WIDTH)) R15 (.clock(clock), .clear(clear), .i_load(w_rin[15]), .i_d(w_bus), .q(w_r_q[15]));

    mini_src_datapath_reg #(.WIDTH(WIDTH)) HI      (.clock(clock), .clear(clear), .i_load(HIin),      .i_d(w_bus),   .q(w_hi_q));
    mini_src_datapath_reg #(.WIDTH(WIDTH)) LO      (.clock(clock), .clear(clear), .i_load(LOin),      .i_d(w_bus),   .q(w_lo_q));
    mini_src_datapath_reg #(.WIDTH(WIDTH)) PC      (.clock(clock), .clear(clear), .i_load(PCin),      .i_d(w_bus),   .q(w_pc_q));
    mini_src_datapath_reg #(.WIDTH(WIDTH)) IR      (.clock(clock), .clear(clear), .i_load(IRin),      .i_d(w_bus),   .q(w_ir_q));
    mini_src_datapath_reg #(.WIDTH(WIDTH)) MAR     (.clock(clock), .clear(clear), .i_load(MARin),     .i_d(w_bus),   .q(w_mar_q));
    mini_src_datapath_reg #(.WIDTH(WIDTH)) MDR     (.clock(clock), .clear(clear), .i_load(MDRin),     .i_d(w_mdr_d), .q(w_mdr_q));
    mini_src_datapath_reg #(.WIDTH(WIDTH)) Y       (.clock(clock), .clear(clear), .i_load(Yin),       .i_d(w_bus),   .q(w_y_q));
    mini_src_datapath_reg #(.WIDTH(WIDTH)) C       (.clock(clock), .clear(clear), .i_load(Coutin),    .i_d(w_bus),   .q(w_c_q));
    mini_src_datapath_reg #(.WIDTH(WIDTH)) In_Port (.clock(clock), .clear(clear), .i_load(In_Portin), .i_d(w_bus),   .q(w_inport_q));

    assign w_mdr_d     = Read ? Mdatain : w_bus;
    assign Out_Portout = w_inport_q;

    // IR and MAR have no bus driver in this phase; they are observed only
    // through their instance q outputs.
    assign w_unused_ok = ^{w_ir_q, w_mar_q};

    // ---------------- bus: later assignments override earlier ones, so the
    // lowest-priority source is written first and R0 is written last.
    always_comb begin
        w_bus = '0;
        if (Coutout)    w_bus = w_c_q;
        if (In_Portout) w_bus = w_inport_q;
        if (MDRout)     w_bus = w_mdr_q;
        if (PCout)      w_bus = w_pc_q;
        if (Zlowout)    w_bus = r_z[WIDTH-1:0];
        if (Zhighout)   w_bus = r_z[2*WIDTH-1:WIDTH];
        if (LOout)      w_bus = w_lo_q;
        if (HIout)      w_bus = w_hi_q;
        for (int i = 15; i >= 0; i--) begin
            if (w_rout[i]) w_bus = w_r_q[i];
        end
    end

    // ---------------- ALU (A = Y, B = bus) ----------------
    logic [c_SHW-1:0]          w_sh;
    logic [2*WIDTH-1:0]        w_dbl, w_ror_full, w_rol_full;
    logic [WIDTH-1:0]          w_shra;
    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [WIDTH-1:0]   w_quot, w_rem;

    assign w_sh       = w_bus[c_SHW-1:0];
    // Rotates are taken from a doubled copy of A so no wrap logic is needed.
    assign w_dbl      = {w_y_q, w_y_q};
    assign w_ror_full = w_dbl >> w_sh;
    assign w_rol_full = w_dbl << w_sh;
    assign w_shra     = $signed(w_y_q) >>> w_sh;
    assign w_prod     = $signed({{WIDTH{w_y_q[WIDTH-1]}}, w_y_q}) *
                        $signed({{WIDTH{w_bus[WIDTH-1]}}, w_bus});
    assign w_quot     = $signed(w_y_q) / $signed(w_bus);
    assign w_rem      = $signed(w_y_q) % $signed(w_bus);

    always_comb begin
        w_alu = '0;
        if (IncPC) begin
            w_alu = {{WIDTH{1'b0}}, w_bus + 1'b1};
        end else begin
            case (ALU_Control)
                c_OP_ADD:  w_alu = {{WIDTH{1'b0}}, w_y_q + w_bus};
                c_OP_SUB:  w_alu = {{WIDTH{1'b0}}, w_y_q - w_bus};
                c_OP_AND:  w_alu = {{WIDTH{1'b0}}, w_y_q & w_bus};
                c_OP_OR:   w_alu = {{WIDTH{1'b0}}, w_y_q | w_bus};
                c_OP_NEG:  w_alu = {{WIDTH{1'b0}}, -w_y_q};
                c_OP_NOT:  w_alu = {{WIDTH{1'b0}}, ~w_y_q};
                c_OP_SHR:  w_alu = {{WIDTH{1'b0}}, w_y_q >> w_sh};
                c_OP_SHRA: w_alu = {{WIDTH{1'b0}}, w_shra};
                c_OP_SHL:  w_alu = {{WIDTH{1'b0}}, w_y_q << w_sh};
                c_OP_ROR:  w_alu = {{WIDTH{1'b0}}, w_ror_full[WIDTH-1:0]};
                c_OP_ROL:  w_alu = {{WIDTH{1'b0}}, w_rol_full[2*WIDTH-1:WIDTH]};
                c_OP_MUL:  w_alu = w_prod;
                c_OP_DIV:  w_alu = (w_bus == '0) ? '0 : {w_rem, w_quot};
                default:   w_alu = '0;
            endcase
        end
    end

    // ---------------- Z: full load from ALU beats half loads from bus ----
    always_ff @(posedge clock) begin
        if (!clear) begin
            r_z <= '0;
        end else if (Zin) begin
            r_z <= w_alu;
        end else begin
            if (Zhighin) r_z[2*WIDTH-1:WIDTH] <= w_bus;
            if (Zlowin)  r_z[WIDTH-1:0]       <= w_bus;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mini_src_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_mini_src_datapath
// Purpose  : Self-checking bench for mini_src_datapath. Control steps are
//            issued one clock at a time; results are routed to In_Port (or
//            read from IR/MAR) and compared by a scoreboard monitor against
//            expectations from a behavioural ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mini_src_datapath;
    localparam int S_HI = 16, S_LO = 17, S_ZH = 18, S_ZL = 19;
    localparam int S_PC = 20, S_MDR = 21, S_INP = 22, S_C = 23;

    logic        clock = 1'b0;
    logic        clear;
    logic [15:0] rin, rout;
    logic [7:0]  xin, xout;
    logic        rd, irin, marin, yin, zin, incpc;
    logic [31:0] mdata;
    logic [4:0]  aluc;
    logic [31:0] outp;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q [$];
    int          sel_q [$];
    string       name_q[$];
    logic        obs_valid = 1'b0;

    always #5 clock = ~clock;

    mini_src_datapath dut (
        .clock(clock), .clear(clear),
        .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
        .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
        .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .HIin(xin[0]), .LOin(xin[1]), .Zhighin(xin[2]), .Zlowin(xin[3]),
        .PCin(xin[4]), .MDRin(xin[5]), .In_Portin(xin[6]), .Coutin(xin[7]),
        .Read(rd), .IRin(irin), .MARin(marin), .Yin(yin), .Zin(zin),
        .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
        .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
        .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .HIout(xout[0]), .LOout(xout[1]), .Zhighout(xout[2]), .Zlowout(xout[3]),
        .PCout(xout[4]), .MDRout(xout[5]), .In_Portout(xout[6]), .Coutout(xout[7]),
        .IncPC(incpc), .Mdatain(mdata), .ALU_Control(aluc), .Out_Portout(outp)
    );

    // ---------------- behavioural ALU model ----------------
    function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic inc);
        logic [31:0] t;
        int          s;
        int          qq, rr;
        longint      p;
        s = int'(b[4:0]);
        t = a;
        if (inc) return {32'd0, b + 32'd1};
        case (op)
            5'd0:  return {32'd0, a + b};
            5'd1:  return {32'd0, a - b};
            5'd2:  return {32'd0, a & b};
            5'd3:  return {32'd0, a | b};
            5'd4:  return {32'd0, 32'd0 - a};
            5'd5:  return {32'd0, ~a};
            5'd6:  return {32'd0, a >> s};
            5'd7:  begin t = int'(a) >>> s; return {32'd0, t}; end
            5'd8:  return {32'd0, a << s};
            5'd9:  begin repeat (s) t = {t[0], t[31:1]}; return {32'd0, t}; end
            5'd10: begin repeat (s) t = {t[30:0], t[31]}; return {32'd0, t}; end
            5'd11: begin p = longint'(int'(a)) * longint'(int'(b)); return p; end
            5'd12: begin
                if (b == 32'd0) return 64'd0;
                qq = int'(a) / int'(b);
                rr = int'(a) % int'(b);
                return {rr, qq};
            end
            default: return 64'd0;
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        if (obs_valid) begin
            logic [31:0] e, act;
            int          s;
            string       n;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty: observation with no expectation");
            end else begin
                e = exp_q.pop_front();
                s = sel_q.pop_front();
                n = name_q.pop_front();
                act = (s == 0) ? outp : (s == 1) ? dut.IR.q : dut.MAR.q;
                if (act !== e) begin
                    failures++;
                    $display("FAIL %s: got %h expected %h", n, act, e);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clr_strobes();
        rin = '0; rout = '0; xin = '0; xout = '0;
        rd = 0; irin = 0; marin = 0; yin = 0; zin = 0; incpc = 0; aluc = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        clr_strobes();
        obs_valid = 1'b0;
    endtask

    task automatic set_out(input int src);
        if (src < 16) rout[src] = 1'b1; else xout[src-16] = 1'b1;
    endtask

    task automatic set_in(input int dst);
        if (dst < 16) rin[dst] = 1'b1; else xin[dst-16] = 1'b1;
    endtask

    // sel: 0 = Out_Portout, 1 = IR, 2 = MAR
    task automatic check_now(input int sel, input logic [31:0] e, input string n);
        exp_q.push_back(e); sel_q.push_back(sel); name_q.push_back(n);
        obs_valid = 1'b1;
        tick();
    endtask

    task automatic observe(input int src, input logic [31:0] e, input string n);
        set_out(src); set_in(S_INP); tick();
        check_now(0, e, n);
    endtask

    task automatic mem_to_reg(input int dst, input logic [31:0] v);
        mdata = v; rd = 1; set_in(S_MDR); tick();
        set_out(S_MDR); set_in(dst); tick();
    endtask

    task automatic alu_step(input int ysrc, input int bsrc, input logic [4:0] op, input logic inc);
        set_out(ysrc); yin = 1; tick();
        set_out(bsrc); aluc = op; incpc = inc; zin = 1; tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic [63:0] r;
        logic [4:0]  op;
        logic        inc;
        int          dst;
        clr_strobes();
        mdata = '0;
        clear = 0;
        repeat (2) tick();
        clear = 1;

        // reset state
        check_now(0, 32'h0, "reset_outport");
        observe(S_ZL, 32'h0, "reset_zlow");
        observe(S_R4_dummy(), 32'h0, "reset_r4");

        // fetch
        set_out(S_PC); marin = 1; incpc = 1; zin = 1; tick();
        set_out(S_ZL); set_in(S_PC); rd = 1; set_in(S_MDR); mdata = 32'h112B0000; tick();
        set_out(S_MDR); irin = 1; tick();
        check_now(2, 32'h0, "fetch_mar");
        check_now(1, 32'h112B0000, "fetch_ir");
        observe(S_PC, 32'h1, "fetch_pc");
        set_out(S_PC); marin = 1; tick();
        check_now(2, 32'h1, "mar_from_pc1");

        // NOT
        mem_to_reg(4, 32'h34);
        mem_to_reg(7, 32'h45);
        set_out(7); yin = 1; tick();
        aluc = 5'b00101; zin = 1; tick();
        set_out(S_ZL); set_in(4); tick();
        observe(4, 32'hFFFFFFBA, "not_r4");
        observe(7, 32'h00000045, "not_r7");

        // same-cycle drive and load of MDR: bus carries the old value
        set_out(S_MDR); set_in(11); rd = 1; set_in(S_MDR); mdata = 32'hDEAD0001; tick();
        observe(11, 32'h45, "mdr_old_on_bus");
        observe(S_MDR, 32'hDEAD0001, "mdr_new");

        // MUL
        mem_to_reg(1, 32'hFFFFFFFE);
        mem_to_reg(3, 32'h3);
        alu_step(1, 3, 5'b01011, 0);
        observe(S_ZH, 32'hFFFFFFFF, "mul_zhigh");
        observe(S_ZL, 32'hFFFFFFFA, "mul_zlow");
        set_out(S_ZH); set_in(S_HI); tick();
        set_out(S_ZL); set_in(S_LO); tick();
        observe(S_HI, 32'hFFFFFFFF, "mul_hi");
        observe(S_LO, 32'hFFFFFFFA, "mul_lo");

        // DIV, ROR, DIV by zero
        mem_to_reg(1, 32'hFFFFFFF9);
        mem_to_reg(3, 32'h2);
        alu_step(1, 3, 5'b01100, 0);
        observe(S_ZL, 32'hFFFFFFFD, "div_quot");
        observe(S_ZH, 32'hFFFFFFFF, "div_rem");
        mem_to_reg(1, 32'h80000001);
        mem_to_reg(3, 32'h1);
        alu_step(1, 3, 5'b01001, 0);
        observe(S_ZL, 32'hC0000000, "ror_zlow");
        mem_to_reg(3, 32'h0);
        alu_step(1, 3, 5'b01100, 0);
        observe(S_ZL, 32'h0, "div0_zlow");
        observe(S_ZH, 32'h0, "div0_zhigh");

        // bus priority
        mem_to_reg(2, 32'hA5A5A5A5);
        mem_to_reg(9, 32'h00001234);
        set_out(2); set_out(9); set_out(S_C); set_in(10); tick();
        observe(10, 32'hA5A5A5A5, "prio_r2_over_r9");
        set_out(9); set_out(S_HI); set_out(S_INP); set_in(12); tick();
        observe(12, 32'h00001234, "prio_r9_over_hi");

        // Z half loads and Zin priority
        set_out(9); set_in(S_ZH); tick();
        observe(S_ZH, 32'h00001234, "zhighin");
        set_out(2); yin = 1; tick();
        set_out(9); aluc = 5'b00000; zin = 1; set_in(S_ZL); tick();
        observe(S_ZL, 32'hA5A5B7D9, "zin_over_zlowin");
        observe(S_ZH, 32'h0, "zin_zhigh");

        // IncPC overrides ALU_Control
        set_out(9); aluc = 5'b00010; incpc = 1; zin = 1; tick();
        observe(S_ZL, 32'h00001235, "incpc");

        // reset mid-operation
        mem_to_reg(4, 32'h34);
        clear = 0; tick(); clear = 1;
        check_now(0, 32'h0, "midreset_outport");
        observe(4, 32'h0, "midreset_r4");
        observe(S_ZL, 32'h0, "midreset_zlow");
        observe(S_MDR, 32'h0, "midreset_mdr");
        mem_to_reg(5, 32'h77);
        set_in(5); tick();
        observe(5, 32'h0, "idle_bus_zero");

        // MDR from bus, In_Port
        mem_to_reg(7, 32'h45);
        mdata = 32'hFFFF0000;
        set_out(7); set_in(S_MDR); rd = 0; tick();
        observe(S_MDR, 32'h45, "mdr_from_bus");
        mem_to_reg(6, 32'h12);
        observe(6, 32'h12, "inport_0x12");

        // randomized ALU operations
        for (int k = 0; k < 60; k++) begin
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            op  = 5'($urandom_range(0, 15));
            inc = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) b = 32'h0;
            if (op == 5'd12 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'h1;
            r   = alu_ref(op, a, b, inc);
            dst = $urandom_range(3, 15);
            mem_to_reg(1, a);
            mem_to_reg(2, b);
            alu_step(1, 2, op, inc);
            observe(S_ZL, r[31:0], "rand_zlow");
            observe(S_ZH, r[63:32], "rand_zhigh");
            set_out(S_ZL); set_in(dst); tick();
            observe(dst, r[31:0], "rand_move");
        end

        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic int S_R4_dummy();
        return 4;
    endfunction
endmodule
`default_nettype wire
